ir_prefix_seq: RTL and testbench
================================

# ir_prefix_seq

Instruction-register and prefix sequencer sitting directly upstream of `pla_decode`. It latches opcode bytes from the data bus at the end of each fetch, and tracks the Z80 prefix bytes DD/FD/CB/ED, including the DD/FD-CB-d-op form. It presents a stable `ir[7:0]` and one-hot-pair `prefix[4:0]` to `pla_decode`, plus the displacement byte and IX/IY select to the datapath. It also tells the machine-cycle sequencer whether another opcode fetch or two memory reads must follow.

## Interface
Parameters:
- `NOP_OP`, 8'h00, opcode loaded into `ir` on reset and on `ir_clr`.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `db`  in  8  data bus byte.
- `fetch_we`  in  1  one-cycle strobe: `db` holds an opcode-fetch (M1) byte.
- `mread_we`  in  1  one-cycle strobe: `db` holds a memory-read byte (used only in the DD/FD-CB sequence).
- `ir_clr`  in  1  force NOP, prefix XX/IXY0, state IDLE (interrupt/halt entry).
- `ir`  out  8  opcode to `pla_decode`.
- `prefix`  out  5  {IXY0, IXY1, XX, CB, ED} to `pla_decode`.
- `use_iy`  out  1  1 = IY, 0 = IX; meaningful when `prefix[3]`=1.
- `disp`  out  8  displacement byte of a DD/FD-CB instruction.
- `ir_valid`  out  1  one-cycle pulse: `ir`/`prefix` hold a complete instruction.
- `pfx_pending`  out  1  a prefix was consumed; the sequencer must issue another M1 fetch.
- `xycb_reads`  out  1  in a DD/FD-CB sequence; the sequencer must issue memory reads (d, then op).
- `int_block`  out  1  high while any prefix is pending; interrupts are not accepted.

## Operation
- States: IDLE, XY (after DD/FD), CB, ED, XYCB_D, XYCB_OP.
- IDLE, on `fetch_we`:
  - DD → XY, ixy=1, use_iy=0.
  - FD → XY, ixy=1, use_iy=1.
  - CB → CB.
  - ED → ED.
  - Any other byte: `ir`=byte, prefix=10100, `ir_valid` pulse, stay IDLE.
- XY, on `fetch_we`:
  - DD/FD: last one wins (update `use_iy`), stay XY.
  - CB → XYCB_D.
  - ED → ED, ixy kept (prefix will be 01001).
  - Any other byte: `ir`=byte, prefix=01100, `ir_valid`, → IDLE.
- CB, on `fetch_we`: `ir`=byte (any value, including DD/ED/CB), prefix={~ixy,ixy,0,1,0}, `ir_valid`, → IDLE.
- ED, on `fetch_we`: `ir`=byte (any value), prefix={~ixy,ixy,0,0,1}, `ir_valid`, → IDLE.
- XYCB_D, on `mread_we`: `disp`=byte, → XYCB_OP.
- XYCB_OP, on `mread_we`: `ir`=byte, prefix=01010, `ir_valid`, → IDLE.
- `fetch_we` is ignored in XYCB_D and XYCB_OP. `mread_we` is ignored in all other states.
- `ixy` and `use_iy` clear on every return to IDLE after `ir_valid`. `use_iy` output holds its value through the `ir_valid` cycle.
- While a prefix is pending, `ir` and `prefix` hold their last completed values and the decoder sees no new instruction.
- `pfx_pending` = state ∈ {XY, CB, ED}.
- `xycb_reads` = state ∈ {XYCB_D, XYCB_OP}.
- `int_block` = state ≠ IDLE.

## Timing
- All outputs are registered. A strobe in cycle N updates state, `ir`, `prefix` and `disp` at the edge ending cycle N. `ir_valid` is high for exactly cycle N+1.
- Latency from the final opcode byte to `ir_valid` is 1 cycle.
- A prefix costs one extra fetch per prefix byte. There is no bound on DD/FD chains; each byte keeps `int_block`=1.
- Reset values: `ir`=NOP_OP, `prefix`=10100, `use_iy`=0, `disp`=00, `ir_valid`=0, `pfx_pending`=0, `xycb_reads`=0, `int_block`=0, state IDLE.
- Priority: `reset` > `ir_clr` > strobes.
- `ir_clr` gives the reset values for all outputs and state, except that `disp` is held. `ir_clr` does not pulse `ir_valid`.
- `ir_clr` or `reset` asserted mid-sequence (any non-IDLE state) aborts it. The next `fetch_we` is treated as from IDLE.
- `fetch_we` and `mread_we` in the same cycle: only the strobe valid for the current state acts.
- Back-to-back strobes in consecutive cycles are legal; each is processed.

## Test plan
- Reset, then `fetch_we` db=3E → next cycle `ir`=3E, `prefix`=10100, `ir_valid`=1 for one cycle, `int_block`=0.
- FD then 21 → after FD: `pfx_pending`=1, `int_block`=1, `ir` unchanged. After 21: `ir`=21, `prefix`=01100, `use_iy`=1.
- DD, FD, DD, 7E → `use_iy`=0 at the `ir_valid` pulse, `prefix`=01100. Exactly one `ir_valid` pulse.
- FD CB (fetch), then 05, C6 (mread) → `xycb_reads`=1 for two reads. Result: `disp`=05, `ir`=C6, `prefix`=01010, `use_iy`=1. A `fetch_we` injected during XYCB_D is ignored.
- CB then DD → `ir`=DD, `prefix`=10010. ED then B0 → `ir`=B0, `prefix`=10001. DD ED 4A → `prefix`=01001.
- DD, then `ir_clr` together with `fetch_we`=CB → `ir`=00, `prefix`=10100, `int_block`=0, no `ir_valid`. The next `fetch_we` 76 decodes as `ir`=76, `prefix`=10100.

Source files
------------

// File: rtl/ir_prefix_seq_if.sv
// Bus between the instruction-register/prefix sequencer and its environment.
// The slave side is the sequencer. The master side is the fetch logic or the testbench.
interface ir_prefix_seq_if;
  logic [7:0] db;
  logic       fetch_we;
  logic       mread_we;
  logic       ir_clr;
  logic [7:0] ir;
  logic [4:0] prefix;
  logic       use_iy;
  logic [7:0] disp;
  logic       ir_valid;
  logic       pfx_pending;
  logic       xycb_reads;
  logic       int_block;

  modport slave (
    input  db, fetch_we, mread_we, ir_clr,
    output ir, prefix, use_iy, disp, ir_valid, pfx_pending, xycb_reads, int_block
  );

  modport master (
    output db, fetch_we, mread_we, ir_clr,
    input  ir, prefix, use_iy, disp, ir_valid, pfx_pending, xycb_reads, int_block
  );
endinterface

// File: rtl/ir_prefix_seq.sv
// Z80 instruction register and prefix sequencer (DD/FD/CB/ED and DD/FD-CB-d-op).
// It latches opcodes and presents a stable ir/prefix pair to pla_decode.
module ir_prefix_seq #(
  parameter logic [7:0] NOP_OP = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  ir_prefix_seq_if.slave  bus
);

  localparam logic [7:0] OP_DD = 8'hDD;
  localparam logic [7:0] OP_FD = 8'hFD;
  localparam logic [7:0] OP_CB = 8'hCB;
  localparam logic [7:0] OP_ED = 8'hED;
  localparam logic [4:0] PFX_NONE = 5'b10100;

  typedef enum logic [2:0] {
    S_IDLE, S_XY, S_CB, S_ED, S_XYCB_D, S_XYCB_OP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [4:0] prefix_q, prefix_d;
  logic       use_iy_q, use_iy_d;
  logic [7:0] disp_q, disp_d;
  logic       ir_valid_q, ir_valid_d;
  logic       ixy_q, ixy_d;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    prefix_d   = prefix_q;
    // use_iy survives the ir_valid cycle, then drops unless a new DD/FD reloads it
    use_iy_d   = ir_valid_q ? 1'b0 : use_iy_q;
    disp_d     = disp_q;
    ir_valid_d = 1'b0;
    ixy_d      = ixy_q;

    if (bus.ir_clr) begin
      state_d  = S_IDLE;
      ir_d     = NOP_OP;
      prefix_d = PFX_NONE;
      use_iy_d = 1'b0;
      ixy_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.fetch_we) begin
          unique case (bus.db)
            OP_DD: begin state_d = S_XY; ixy_d = 1'b1; use_iy_d = 1'b0; end
            OP_FD: begin state_d = S_XY; ixy_d = 1'b1; use_iy_d = 1'b1; end
            OP_CB: state_d = S_CB;
            OP_ED: state_d = S_ED;
            default: begin
              ir_d       = bus.db;
              prefix_d   = PFX_NONE;
              ir_valid_d = 1'b1;
              ixy_d      = 1'b0;
            end
          endcase
        end
        S_XY: if (bus.fetch_we) begin
          unique case (bus.db)
            OP_DD: use_iy_d = 1'b0;
            OP_FD: use_iy_d = 1'b1;
            OP_CB: state_d = S_XYCB_D;
            OP_ED: state_d = S_ED;
            default: begin
              ir_d       = bus.db;
              prefix_d   = 5'b01100;
              ir_valid_d = 1'b1;
              ixy_d      = 1'b0;
              state_d    = S_IDLE;
            end
          endcase
        end
        S_CB: if (bus.fetch_we) begin
          ir_d       = bus.db;
          prefix_d   = {~ixy_q, ixy_q, 3'b010};
          ir_valid_d = 1'b1;
          ixy_d      = 1'b0;
          state_d    = S_IDLE;
        end
        S_ED: if (bus.fetch_we) begin
          ir_d       = bus.db;
          prefix_d   = {~ixy_q, ixy_q, 3'b001};
          ir_valid_d = 1'b1;
          ixy_d      = 1'b0;
          state_d    = S_IDLE;
        end
        S_XYCB_D: if (bus.mread_we) begin
          disp_d  = bus.db;
          state_d = S_XYCB_OP;
        end
        S_XYCB_OP: if (bus.mread_we) begin
          ir_d       = bus.db;
          prefix_d   = 5'b01010;
          ir_valid_d = 1'b1;
          ixy_d      = 1'b0;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ir_q       <= NOP_OP;
      prefix_q   <= PFX_NONE;
      use_iy_q   <= 1'b0;
      disp_q     <= '0;
      ir_valid_q <= 1'b0;
      ixy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      prefix_q   <= prefix_d;
      use_iy_q   <= use_iy_d;
      disp_q     <= disp_d;
      ir_valid_q <= ir_valid_d;
      ixy_q      <= ixy_d;
    end
  end

  assign bus.ir          = ir_q;
  assign bus.prefix      = prefix_q;
  assign bus.use_iy      = use_iy_q;
  assign bus.disp        = disp_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.pfx_pending = (state_q == S_XY) || (state_q == S_CB) || (state_q == S_ED);
  assign bus.xycb_reads  = (state_q == S_XYCB_D) || (state_q == S_XYCB_OP);
  assign bus.int_block   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_prefix_seq.sv
// Scoreboard bench for ir_prefix_seq: directed prefix sequences queue their expected decode.
// A negedge monitor checks each ir_valid pulse against that queue.
module tb_ir_prefix_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ir_prefix_seq_if intf();

  ir_prefix_seq #(.NOP_OP(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  typedef struct packed {
    logic [7:0] ir;
    logic [4:0] prefix;
    logic       use_iy;
    logic [7:0] disp;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_insn(input logic [7:0] ir, input logic [4:0] pfx, input logic iy,
                             input logic [7:0] disp);
    exp_t e;
    e.ir = ir; e.prefix = pfx; e.use_iy = iy; e.disp = disp;
    exp_q.push_back(e);
  endtask

  // Callers start at a negedge; the strobe is sampled at the next posedge
  task automatic fetch(input logic [7:0] b);
    intf.db = b; intf.fetch_we = 1'b1;
    @(negedge clk);
    intf.fetch_we = 1'b0;
  endtask

  task automatic mread(input logic [7:0] b);
    intf.db = b; intf.mread_we = 1'b1;
    @(negedge clk);
    intf.mread_we = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && intf.ir_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ir_valid", {24'h0, intf.ir}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_ir",     {24'h0, intf.ir},     {24'h0, e.ir});
        check("sb_prefix", {27'h0, intf.prefix}, {27'h0, e.prefix});
        check("sb_use_iy", {31'h0, intf.use_iy}, {31'h0, e.use_iy});
        check("sb_disp",   {24'h0, intf.disp},   {24'h0, e.disp});
      end
    end
  end

  initial begin
    intf.db = 8'h00; intf.fetch_we = 1'b0; intf.mread_we = 1'b0; intf.ir_clr = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check("rst_ir",       {24'h0, intf.ir},     32'h00);
    check("rst_prefix",   {27'h0, intf.prefix}, 32'b10100);
    check("rst_use_iy",   {31'h0, intf.use_iy}, 32'h0);
    check("rst_disp",     {24'h0, intf.disp},   32'h00);
    check("rst_ir_valid", {31'h0, intf.ir_valid}, 32'h0);
    check("rst_pending",  {31'h0, intf.pfx_pending}, 32'h0);
    check("rst_xycb",     {31'h0, intf.xycb_reads}, 32'h0);
    check("rst_int_blk",  {31'h0, intf.int_block}, 32'h0);

    // Plain opcode
    expect_insn(8'h3E, 5'b10100, 1'b0, 8'h00);
    fetch(8'h3E);
    check("plain_int_block", {31'h0, intf.int_block}, 32'h0);
    idle(1);
    check("plain_pulse_one_cycle", {31'h0, intf.ir_valid}, 32'h0);

    // FD 21
    fetch(8'hFD);
    check("fd_pending",   {31'h0, intf.pfx_pending}, 32'h1);
    check("fd_int_block", {31'h0, intf.int_block}, 32'h1);
    check("fd_ir_held",   {24'h0, intf.ir}, 32'h3E);
    check("fd_no_valid",  {31'h0, intf.ir_valid}, 32'h0);
    check("fd_use_iy",    {31'h0, intf.use_iy}, 32'h1);
    expect_insn(8'h21, 5'b01100, 1'b1, 8'h00);
    fetch(8'h21);
    check("fd21_pending_clr", {31'h0, intf.pfx_pending}, 32'h0);
    idle(1);
    check("use_iy_cleared", {31'h0, intf.use_iy}, 32'h0);

    // DD FD DD 7E back-to-back; last prefix wins
    expect_insn(8'h7E, 5'b01100, 1'b0, 8'h00);
    fetch(8'hDD); fetch(8'hFD);
    check("chain_use_iy_fd", {31'h0, intf.use_iy}, 32'h1);
    fetch(8'hDD); fetch(8'h7E);
    idle(2);

    // FD CB d op, with a stray fetch in XYCB_D and a stray mread in IDLE
    fetch(8'hFD); fetch(8'hCB);
    check("xycb_reads_d",   {31'h0, intf.xycb_reads}, 32'h1);
    check("xycb_no_pend",   {31'h0, intf.pfx_pending}, 32'h0);
    fetch(8'h77);
    check("xycb_fetch_ign", {31'h0, intf.xycb_reads}, 32'h1);
    check("xycb_ir_held",   {24'h0, intf.ir}, 32'h7E);
    mread(8'h05);
    check("xycb_disp",      {24'h0, intf.disp}, 32'h05);
    check("xycb_reads_op",  {31'h0, intf.xycb_reads}, 32'h1);
    expect_insn(8'hC6, 5'b01010, 1'b1, 8'h05);
    mread(8'hC6);
    check("xycb_done",      {31'h0, intf.xycb_reads}, 32'h0);
    check("xycb_int_clr",   {31'h0, intf.int_block}, 32'h0);
    idle(1);
    mread(8'hAA);
    check("idle_mread_ign", {24'h0, intf.disp}, 32'h05);

    // CB DD, ED B0, DD ED 4A
    expect_insn(8'hDD, 5'b10010, 1'b0, 8'h05);
    fetch(8'hCB); fetch(8'hDD);
    expect_insn(8'hB0, 5'b10001, 1'b0, 8'h05);
    fetch(8'hED); fetch(8'hB0);
    expect_insn(8'h4A, 5'b01001, 1'b0, 8'h05);
    fetch(8'hDD); fetch(8'hED); fetch(8'h4A);
    idle(2);

    // ir_clr beats a simultaneous fetch
    fetch(8'hDD);
    intf.db = 8'hCB; intf.fetch_we = 1'b1; intf.ir_clr = 1'b1;
    @(negedge clk);
    intf.fetch_we = 1'b0; intf.ir_clr = 1'b0;
    check("clr_ir",        {24'h0, intf.ir}, 32'h00);
    check("clr_prefix",    {27'h0, intf.prefix}, 32'b10100);
    check("clr_int_block", {31'h0, intf.int_block}, 32'h0);
    check("clr_no_valid",  {31'h0, intf.ir_valid}, 32'h0);
    check("clr_disp_held", {24'h0, intf.disp}, 32'h05);
    expect_insn(8'h76, 5'b10100, 1'b0, 8'h05);
    fetch(8'h76);
    idle(1);

    // Reset aborts an XYCB sequence and clears disp
    fetch(8'hFD); fetch(8'hCB);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rst_abort_xycb", {31'h0, intf.xycb_reads}, 32'h0);
    check("rst_abort_iy",   {31'h0, intf.use_iy}, 32'h0);
    expect_insn(8'h3E, 5'b10100, 1'b0, 8'h00);
    fetch(8'h3E);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
